delay_line: RTL and testbench



---
 rtl/delay_line_pkg.sv | 36 +++
 rtl/delay_line_stage.sv | 35 +++
 rtl/delay_line.sv | 101 ++++++++++
 tb/tb_delay_line.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_pkg
// Purpose  : Shared helpers and types for the multi-stage video delay line.
// Revision : 1.0 - initial release
// ============================================================================
package delay_line_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Fill counter must be able to hold DEPTH itself, hence DEPTH+1 codes.
    function automatic int fill_width(input int depth);
        return clog2(depth + 1);
    endfunction

    localparam int STAGE_DATA_W  = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int FILL_W_DEF    = fill_width(DEFAULT_DEPTH);

    typedef struct packed {
        logic                    valid;
        logic [STAGE_DATA_W-1:0] data;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/delay_line_stage.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_stage
// Purpose  : One {valid, data} register; flush clears valid only.
// Revision : 1.0 - initial release
// ============================================================================
module delay_line_stage
    import delay_line_pkg::*;
#(
    parameter int N = STAGE_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         flush,
    input  logic         d_valid,
    input  logic [N-1:0] d_data,
    output logic         q_valid,
    output logic [N-1:0] q_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (ce) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Purpose  : Tap-selectable ce-gated delay line with valid tracking, flush and
//            fill indication. Define DELAY_LINE_OREG_EN to register the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module delay_line
    import delay_line_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int TAP_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic [N-1:0]     idata,
    input  logic             ivalid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [N-1:0]     odata,
    output logic             ovalid,
    output logic             primed
);

    localparam int                FILL_W   = fill_width(DEPTH);
    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

    logic [N-1:0]      stage_data  [DEPTH];
    logic              stage_valid [DEPTH];
    logic [FILL_W-1:0] fill_cnt;
    logic [TAP_W-1:0]  tap;
    logic [N-1:0]      mux_data;
    logic              mux_valid;
    logic              mux_primed;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic [N-1:0] d_data;
            logic         d_valid;
            if (k == 0) begin : g_head
                assign d_data  = idata;
                assign d_valid = ivalid;
            end else begin : g_body
                assign d_data  = stage_data[k-1];
                assign d_valid = stage_valid[k-1];
            end
            delay_line_stage #(.N(N)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .ce      (ce),
                .flush   (flush),
                .d_valid (d_valid),
                .d_data  (d_data),
                .q_valid (stage_valid[k]),
                .q_data  (stage_data[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (flush) begin
            fill_cnt <= '0;
        end else if (ce && (fill_cnt != FULL)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Out-of-range taps (non power-of-two DEPTH) clamp to the last stage.
    assign tap        = (32'(tap_sel) >= DEPTH) ? LAST_TAP : tap_sel;
    assign mux_data   = stage_data[tap];
    assign mux_valid  = stage_valid[tap];
    assign mux_primed = (fill_cnt > FILL_W'(tap));

`ifdef DELAY_LINE_OREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata  <= '0;
            ovalid <= 1'b0;
            primed <= 1'b0;
        end else if (flush) begin
            ovalid <= 1'b0;
            primed <= 1'b0;
        end else if (ce) begin
            odata  <= mux_data;
            ovalid <= mux_valid;
            primed <= mux_primed;
        end
    end
`else
    assign odata  = mux_data;
    assign ovalid = mux_valid;
    assign primed = mux_primed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line
// Purpose  : Directed self-checking bench for delay_line (combinational output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_line;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic [7:0] idata;
    logic       ivalid;
    logic [1:0] tap_sel;
    logic [1:0] tap_sel3;
    logic [7:0] odata;
    logic       ovalid;
    logic       primed;
    logic [7:0] odata3;
    logic       ovalid3;
    logic       primed3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_line #(.N(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .flush   (flush),
        .idata   (idata),
        .ivalid  (ivalid),
        .tap_sel (tap_sel),
        .odata   (odata),
        .ovalid  (ovalid),
        .primed  (primed)
    );

    delay_line #(.N(8), .DEPTH(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .flush   (flush),
        .idata   (idata),
        .ivalid  (ivalid),
        .tap_sel (tap_sel3),
        .odata   (odata3),
        .ovalid  (ovalid3),
        .primed  (primed3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic p);
        chk({tag, ".odata"},  32'(odata),  32'(d));
        chk({tag, ".ovalid"}, 32'(ovalid), 32'(v));
        chk({tag, ".primed"}, 32'(primed), 32'(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fill_vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] ramp_vals [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    initial begin
        rst_n    = 1'b0;
        ce       = 1'b0;
        flush    = 1'b0;
        idata    = 8'h00;
        ivalid   = 1'b0;
        tap_sel  = 2'd3;
        tap_sel3 = 2'd3;
        tick();
        tick();
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Fill from reset at tap 3: first valid after the 4th edge.
        ce     = 1'b1;
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idata = fill_vals[i];
            tick();
            if (i < 3)       chk_out("fill.empty", 8'h00, 1'b0, 1'b0);
            else if (i == 3) chk_out("fill.first", 8'h11, 1'b1, 1'b1);
            else             chk_out("fill.next",  8'h22, 1'b1, 1'b1);
        end

        // CE gating at tap 1.
        tap_sel = 2'd1;
        idata   = 8'hA0;
        tick();
        chk_out("ce.edge1", 8'h55, 1'b1, 1'b1);
        idata = 8'hA1;
        tick();
        chk_out("ce.edge2", 8'hA0, 1'b1, 1'b1);
        ce    = 1'b0;
        idata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("ce.hold", 8'hA0, 1'b1, 1'b1);
        end
        ce    = 1'b1;
        idata = 8'hA2;
        tick();
        chk_out("ce.nodup", 8'hA1, 1'b1, 1'b1);

        // ivalid low still shifts data with a cleared valid bit.
        ivalid = 1'b0;
        idata  = 8'hB0;
        tick();
        chk_out("inv.prev", 8'hA2, 1'b1, 1'b1);
        ivalid = 1'b1;
        idata  = 8'hB1;
        tick();
        chk_out("inv.bubble", 8'hB0, 1'b0, 1'b1);

        // Load 01..04 so stage0..3 hold 04,03,02,01.
        for (int i = 0; i < 4; i++) begin
            idata = ramp_vals[i];
            tick();
        end
        ce = 1'b0;
        tap_sel = 2'd0; #1;
        chk_out("tap0", 8'h04, 1'b1, 1'b1);
        tap_sel = 2'd2; #1;
        chk_out("tap2", 8'h02, 1'b1, 1'b1);
        tap_sel = 2'd3; #1;
        chk_out("tap3", 8'h01, 1'b1, 1'b1);
        chk("clamp.d3.odata",  32'(odata3),  32'h02);
        chk("clamp.d3.ovalid", 32'(ovalid3), 32'h1);
        chk("clamp.d3.primed", 32'(primed3), 32'h1);

        // Flush with ce high: valid/fill cleared, FF dropped, data kept.
        ce    = 1'b1;
        flush = 1'b1;
        idata = 8'hFF;
        tick();
        flush = 1'b0;
        ce    = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t); #1;
            chk_out("flush", 8'h04 - 8'(t), 1'b0, 1'b0);
        end

        // One edge after flush primes tap 0 only.
        ce      = 1'b1;
        idata   = 8'h5A;
        tap_sel = 2'd0;
        tick();
        chk_out("refill.tap0", 8'h5A, 1'b1, 1'b1);
        tap_sel = 2'd1; #1;
        chk_out("refill.tap1", 8'h04, 1'b0, 1'b0);

        // Asynchronous reset between edges while streaming at tap 1.
        idata = 8'h5B;
        tick();
        chk_out("arst.before", 8'h5A, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("arst.now", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        idata = 8'hC0;
        tick();
        chk_out("arst.edge1", 8'h00, 1'b0, 1'b0);
        idata = 8'hC1;
        tick();
        chk_out("arst.edge2", 8'hC0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
